// File: rtl/CPU_Types.sv
// Shared CPU bus types.
// Fetch-responder state encoding and the bus word width.
package CPU_Types;

  localparam int BUS_W = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HIT,
    S_READ,
    S_RESPOND,
    S_ERROR,
    S_LOAD,
    S_PF_ISSUE,
    S_PF_CAPTURE
  } ifetch_state_t;

endpackage

// File: rtl/CPU_BRAM.sv
// Single-port-write / single-port-read block RAM.
// Synchronous read with one cycle of latency; contents are never reset.
module CPU_BRAM #(
  parameter int WIDTH    = 32,
  parameter int SIZE     = 4096,
  parameter int ADDR_LSH = 0,
  localparam int AW      = $clog2(SIZE)
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [AW+ADDR_LSH-1:0]  waddr,
  input  logic [WIDTH-1:0]        wdata,
  input  logic                    re,
  input  logic [AW+ADDR_LSH-1:0]  raddr,
  output logic [WIDTH-1:0]        rdata
);

  logic [WIDTH-1:0] mem [SIZE];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr[AW+ADDR_LSH-1:ADDR_LSH]] <= wdata;
    if (re) rdata_q <= mem[raddr[AW+ADDR_LSH-1:ADDR_LSH]];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/cpu_ifetch_responder.sv
// Instruction-fetch responder: windowed on-chip memory with wait states,
// a one-entry sequential prefetch buffer, a loader port and hit/miss counts.
module cpu_ifetch_responder
  import CPU_Types::*;
#(
  parameter int          SIZE    = 12,
  parameter logic [31:0] BASE    = 32'h0000_0000,
  parameter int          LATENCY = 0
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_request,
  input  logic [BUS_W-1:0]  i_address,
  output logic [BUS_W-1:0]  o_rdata,
  output logic              o_ready,
  output logic              o_error,
  input  logic              i_load_request,
  input  logic [BUS_W-1:0]  i_load_address,
  input  logic [BUS_W-1:0]  i_load_wdata,
  output logic              o_load_ready,
  output logic [BUS_W-1:0]  o_hit,
  output logic [BUS_W-1:0]  o_miss
);

  localparam int CW = 16;

  function automatic logic in_win(input logic [BUS_W-1:0] a);
    return ((a - BASE) >> (SIZE + 2)) == 32'd0;
  endfunction

  function automatic logic [SIZE-1:0] idx(input logic [BUS_W-1:0] a);
    return SIZE'((a - BASE) >> 2);
  endfunction

  ifetch_state_t    state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [BUS_W-1:0] addr_q, addr_d;
  logic [BUS_W-1:0] ld_addr_q, ld_addr_d;
  logic [BUS_W-1:0] ld_data_q, ld_data_d;
  logic             pf_valid_q, pf_valid_d;
  logic             pf_pend_q, pf_pend_d;
  logic [BUS_W-1:0] pf_addr_q, pf_addr_d;
  logic [BUS_W-1:0] pf_data_q, pf_data_d;
  logic [BUS_W-1:0] hit_q, hit_d;
  logic [BUS_W-1:0] miss_q, miss_d;

  logic             mem_we;
  logic             mem_re;
  logic [SIZE-1:0]  mem_waddr;
  logic [SIZE-1:0]  mem_raddr;
  logic [BUS_W-1:0] mem_rdata;

  CPU_BRAM #(
    .WIDTH   (BUS_W),
    .SIZE    (1 << SIZE),
    .ADDR_LSH(0)
  ) u_bram (
    .clk  (i_clock),
    .we   (mem_we),
    .waddr(mem_waddr),
    .wdata(ld_data_q),
    .re   (mem_re),
    .raddr(mem_raddr),
    .rdata(mem_rdata)
  );

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      ld_addr_q  <= '0;
      ld_data_q  <= '0;
      pf_valid_q <= 1'b0;
      pf_pend_q  <= 1'b0;
      pf_addr_q  <= '0;
      pf_data_q  <= '0;
      hit_q      <= '0;
      miss_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      ld_addr_q  <= ld_addr_d;
      ld_data_q  <= ld_data_d;
      pf_valid_q <= pf_valid_d;
      pf_pend_q  <= pf_pend_d;
      pf_addr_q  <= pf_addr_d;
      pf_data_q  <= pf_data_d;
      hit_q      <= hit_d;
      miss_q     <= miss_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    ld_addr_d  = ld_addr_q;
    ld_data_d  = ld_data_q;
    pf_valid_d = pf_valid_q;
    pf_pend_d  = pf_pend_q;
    pf_addr_d  = pf_addr_q;
    pf_data_d  = pf_data_q;
    hit_d      = hit_q;
    miss_d     = miss_q;
    unique case (state_q)
      S_IDLE: begin
        addr_d    = i_address;
        ld_addr_d = i_load_address;
        ld_data_d = i_load_wdata;
        cnt_d     = CW'(LATENCY);
        if (i_request) begin
          if (!in_win(i_address))
            state_d = S_ERROR;
          else if (pf_valid_q &&
                   i_address[31:2] == pf_addr_q[31:2])
            state_d = S_HIT;
          else
            state_d = S_READ;
        end else if (i_load_request) begin
          state_d = S_LOAD;
        end else if (pf_pend_q) begin
          // a sequential address past the window end is dropped here
          if (in_win(pf_addr_q)) state_d = S_PF_ISSUE;
          else                   pf_pend_d = 1'b0;
        end
      end
      S_HIT: begin
        hit_d      = hit_q + 32'd1;
        pf_addr_d  = pf_addr_q + 32'd4;
        pf_valid_d = 1'b0;
        pf_pend_d  = 1'b1;
        state_d    = S_IDLE;
      end
      S_READ: begin
        if (cnt_q == '0) state_d = S_RESPOND;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_RESPOND: begin
        miss_d     = miss_q + 32'd1;
        pf_addr_d  = addr_q + 32'd4;
        pf_valid_d = 1'b0;
        pf_pend_d  = 1'b1;
        state_d    = S_IDLE;
      end
      S_ERROR: begin
        pf_pend_d = 1'b0;
        state_d   = S_IDLE;
      end
      S_LOAD: begin
        pf_valid_d = 1'b0;
        pf_pend_d  = 1'b0;
        state_d    = S_IDLE;
      end
      S_PF_ISSUE: state_d = S_PF_CAPTURE;
      S_PF_CAPTURE: begin
        pf_data_d  = mem_rdata;
        pf_valid_d = 1'b1;
        pf_pend_d  = 1'b0;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    o_ready      = 1'b0;
    o_error      = 1'b0;
    o_load_ready = 1'b0;
    o_rdata      = '0;
    mem_re       = 1'b0;
    mem_we       = 1'b0;
    mem_raddr    = idx(addr_q);
    mem_waddr    = idx(ld_addr_q);
    unique case (state_q)
      S_HIT: begin
        o_ready = 1'b1;
        o_rdata = pf_data_q;
      end
      S_READ: mem_re = 1'b1;
      S_RESPOND: begin
        o_ready = 1'b1;
        o_rdata = mem_rdata;
      end
      S_ERROR: begin
        o_ready = 1'b1;
        o_error = 1'b1;
      end
      S_LOAD: begin
        o_load_ready = 1'b1;
        mem_we       = in_win(ld_addr_q);
      end
      S_PF_ISSUE: begin
        mem_re    = 1'b1;
        mem_raddr = idx(pf_addr_q);
      end
      default: ;
    endcase
  end

  assign o_hit  = hit_q;
  assign o_miss = miss_q;

endmodule

// File: tb/tb_cpu_ifetch_responder.sv
// Directed plus randomized bench for cpu_ifetch_responder against a
// transaction-level timing and data model.
module tb_cpu_ifetch_responder;

  localparam int          SIZE  = 6;
  localparam logic [31:0] BASE  = 32'h0000_0400;
  localparam int          LAT   = 2;
  localparam int          WORDS = 1 << SIZE;
  localparam logic [31:0] WIN   = 32'(4 * WORDS);

  logic        clk = 1'b0;
  logic        i_reset;
  logic        i_request;
  logic [31:0] i_address;
  logic [31:0] o_rdata;
  logic        o_ready;
  logic        o_error;
  logic        i_load_request;
  logic [31:0] i_load_address;
  logic [31:0] i_load_wdata;
  logic        o_load_ready;
  logic [31:0] o_hit;
  logic [31:0] o_miss;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cpu_ifetch_responder #(
    .SIZE   (SIZE),
    .BASE   (BASE),
    .LATENCY(LAT)
  ) dut (
    .i_clock       (clk),
    .i_reset       (i_reset),
    .i_request     (i_request),
    .i_address     (i_address),
    .o_rdata       (o_rdata),
    .o_ready       (o_ready),
    .o_error       (o_error),
    .i_load_request(i_load_request),
    .i_load_address(i_load_address),
    .i_load_wdata  (i_load_wdata),
    .o_load_ready  (o_load_ready),
    .o_hit         (o_hit),
    .o_miss        (o_miss)
  );

  // reference model state
  logic [31:0] mem [WORDS];
  bit          m_pv;
  bit          m_pend;
  logic [31:0] m_pa;
  logic [31:0] m_pd;
  logic [31:0] m_hit;
  logic [31:0] m_miss;
  int          t_idle;
  logic [31:0] last_a;

  function automatic bit inwin(input logic [31:0] a);
    return (a - BASE) < WIN;
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // decision cycle of the next operation raised in cycle t
  task automatic decide(input int t, output int d);
    if (t <= t_idle) begin
      d = t_idle;
    end else if (m_pend) begin
      d = (t > t_idle + 3) ? t : t_idle + 3;
      m_pv   = 1;
      m_pend = 0;
      m_pd   = mem[widx(m_pa)];
    end else begin
      d = t;
    end
  endtask

  task automatic gap_wait(input int gap);
    if (gap > 0) begin
      i_request      = 1'b0;
      i_load_request = 1'b0;
      for (int i = 0; i < gap; i++) begin
        @(negedge clk);
        if (i == 0) begin
          chk("idle_ready", {31'd0, o_ready}, 32'd0);
          chk("idle_rdata", o_rdata, 32'd0);
          chk("idle_hit", o_hit, m_hit);
          chk("idle_miss", o_miss, m_miss);
        end
      end
    end
  endtask

  task automatic wait_ack(output int got);
    got = -1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (o_ready || o_load_ready) begin
        got = cyc;
        break;
      end
    end
  endtask

  task automatic fetch(input logic [31:0] a, input int gap);
    int t;
    int d;
    int rdy;
    int got;
    logic [31:0] ed;
    logic        ee;
    gap_wait(gap);
    i_load_request = 1'b0;
    i_request      = 1'b1;
    i_address      = a;
    t = cyc;
    decide(t, d);
    ee = 1'b0;
    if (!inwin(a)) begin
      rdy = d + 1;
      ed  = 32'd0;
      ee  = 1'b1;
    end else if (m_pv && a[31:2] == m_pa[31:2]) begin
      rdy = d + 1;
      ed  = m_pd;
    end else begin
      rdy = d + 2 + LAT;
      ed  = mem[widx(a)];
    end
    wait_ack(got);
    chk("fetch_cycle", 32'(got), 32'(rdy));
    chk("fetch_ready", {31'd0, o_ready}, 32'd1);
    chk("fetch_ldrdy", {31'd0, o_load_ready}, 32'd0);
    chk("fetch_error", {31'd0, o_error}, {31'd0, ee});
    chk("fetch_data", o_rdata, ed);
    chk("fetch_hitcnt", o_hit, m_hit);
    chk("fetch_misscnt", o_miss, m_miss);
    if (!inwin(a)) begin
      m_pend = 0;
    end else if (m_pv && a[31:2] == m_pa[31:2]) begin
      m_hit++;
      m_pa   = m_pa + 32'd4;
      m_pv   = 0;
      m_pend = inwin(m_pa);
      last_a = a;
    end else begin
      m_miss++;
      m_pa   = a + 32'd4;
      m_pv   = 0;
      m_pend = inwin(m_pa);
      last_a = a;
    end
    t_idle = rdy + 1;
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] w,
                      input int gap);
    int t;
    int d;
    int got;
    gap_wait(gap);
    i_request      = 1'b0;
    i_load_request = 1'b1;
    i_load_address = a;
    i_load_wdata   = w;
    t = cyc;
    decide(t, d);
    wait_ack(got);
    chk("load_cycle", 32'(got), 32'(d + 1));
    chk("load_ready", {31'd0, o_load_ready}, 32'd1);
    chk("load_fetchrdy", {31'd0, o_ready}, 32'd0);
    if (inwin(a)) mem[widx(a)] = w;
    m_pv   = 0;
    m_pend = 0;
    t_idle = d + 2;
  endtask

  task automatic reset_check(input string tag);
    chk({tag, "_ready"}, {31'd0, o_ready}, 32'd0);
    chk({tag, "_error"}, {31'd0, o_error}, 32'd0);
    chk({tag, "_ldrdy"}, {31'd0, o_load_ready}, 32'd0);
    chk({tag, "_rdata"}, o_rdata, 32'd0);
    chk({tag, "_hit"}, o_hit, 32'd0);
    chk({tag, "_miss"}, o_miss, 32'd0);
  endtask

  task automatic model_reset();
    m_pv   = 0;
    m_pend = 0;
    m_pa   = 32'd0;
    m_pd   = 32'd0;
    m_hit  = 32'd0;
    m_miss = 32'd0;
  endtask

  initial begin
    logic [31:0] a;
    int r;
    int g;
    for (int i = 0; i < WORDS; i++) mem[i] = 32'd0;
    model_reset();
    last_a         = BASE;
    i_reset        = 1'b1;
    i_request      = 1'b0;
    i_address      = 32'd0;
    i_load_request = 1'b0;
    i_load_address = 32'd0;
    i_load_wdata   = 32'd0;
    repeat (3) @(negedge clk);
    reset_check("rst");
    i_reset = 1'b0;
    t_idle  = cyc;

    load(BASE, 32'h11, 1);
    load(BASE + 32'd4, 32'h22, 0);
    load(BASE + 32'd8, 32'h33, 0);
    fetch(BASE, 1);
    fetch(BASE + 32'd4, 4);
    fetch(BASE + 32'd8, 4);
    fetch(BASE + WIN, 2);
    fetch(BASE - 32'd4, 0);
    fetch(BASE, 2);
    fetch(BASE + 32'd4, 0);
    load(BASE + 32'd8, 32'hA5A5_0001, 0);
    fetch(BASE + 32'd8, 3);

    // reset while the read of BASE is still waiting
    gap_wait(6);
    i_request = 1'b1;
    i_address = BASE;
    @(negedge clk);
    i_reset   = 1'b1;
    i_request = 1'b0;
    @(negedge clk);
    reset_check("rst_read");
    @(negedge clk);
    reset_check("rst_read2");
    i_reset = 1'b0;
    model_reset();
    t_idle = cyc;
    fetch(BASE, 2);

    for (int i = 3; i < WORDS; i++)
      load(BASE + 32'(4 * i), $urandom, 0);
    load(BASE - 32'd8, 32'hDEAD_BEEF, 1);
    fetch(BASE + WIN - 32'd4, 1);
    fetch(BASE, 3);
    fetch(BASE + 32'd4, 0);

    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 99);
      g = $urandom_range(0, 5);
      if (r < 55) begin
        a = last_a + 32'd4;
        if (!inwin(a)) a = BASE;
        fetch(a | 32'($urandom_range(0, 3)), g);
      end else if (r < 75) begin
        fetch(BASE + 32'(4 * $urandom_range(0, WORDS - 1)), g);
      end else if (r < 85) begin
        if (r[0]) a = BASE + WIN + 32'(4 * $urandom_range(0, 99));
        else      a = BASE - 32'(4 * $urandom_range(1, 99));
        fetch(a, g);
      end else if (r < 97) begin
        load(BASE + 32'(4 * $urandom_range(0, WORDS - 1)), $urandom, g);
      end else begin
        load(BASE + WIN + 32'(4 * $urandom_range(0, 9)), $urandom, g);
      end
    end

    gap_wait(4);
    chk("final_hit", o_hit, m_hit);
    chk("final_miss", o_miss, m_miss);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
